// File: rtl/token_buffer_writer.sv
// Writer side of the packed token bus feeding the VGA text renderer.
// Edits land in a working buffer. That buffer is copied to `numbers` only at
// frame boundaries, so the display never shows a half-edited frame.
//
// state | meaning
// IDLE  | accepting commands; commits a pending frame every cycle it is pending
// CLEAR | blanking one working slot per cycle; no commands, commit held off
module token_buffer_writer #(
  parameter int         MAX_INPUT  = 384,
  parameter int         ROW_TOKENS = 20,
  parameter logic [3:0] BLANK      = 4'hF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_cmd,
  input  logic [3:0]           in_token,
  input  logic                 vga_v_sync,
  output logic [MAX_INPUT-1:0] numbers,
  output logic [6:0]           wr_ptr,
  output logic                 overflow,
  output logic                 frame_commit
);

  localparam int         TOKENS  = MAX_INPUT / 4;
  localparam logic [6:0] TOK_MAX = 7'(TOKENS);
  localparam logic [7:0] ROW_W   = 8'(ROW_TOKENS);

  localparam logic [1:0] CMD_WRITE     = 2'b00;
  localparam logic [1:0] CMD_BACKSPACE = 2'b01;
  localparam logic [1:0] CMD_CLEAR     = 2'b10;
  localparam logic [1:0] CMD_NEWLINE   = 2'b11;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_nxt;
  logic [MAX_INPUT-1:0] work, work_nxt;
  logic [6:0]           wr_ptr_nxt;
  logic                 overflow_nxt;
  logic [6:0]           clr_idx, clr_idx_nxt;
  logic [7:0]           nl_ptr;
  logic                 accept;
  logic                 vs_meta, vs_sync, vs_sync_d;
  logic                 vs_fall;
  logic                 commit_pend;

  // vsync is asynchronous to clk; the synchronizer idles high so reset never fakes an edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_meta   <= 1'b1;
      vs_sync   <= 1'b1;
      vs_sync_d <= 1'b1;
    end else begin
      vs_meta   <= vga_v_sync;
      vs_sync   <= vs_meta;
      vs_sync_d <= vs_sync;
    end
  end

  assign vs_fall = vs_sync_d & ~vs_sync;

  // Next-state, buffer edit and handshake decode
  always_comb begin
    state_nxt    = state;
    work_nxt     = work;
    wr_ptr_nxt   = wr_ptr;
    overflow_nxt = overflow;
    clr_idx_nxt  = clr_idx;
    in_ready     = (state == IDLE);
    accept       = in_valid & in_ready;
    frame_commit = (state == IDLE) & commit_pend;
    // A newline at column 0 still moves down a full row; the result is clamped to the end.
    nl_ptr       = (({1'b0, wr_ptr} / ROW_W) + 8'd1) * ROW_W;
    case (state)
      IDLE: begin
        if (accept) begin
          case (in_cmd)
            CMD_WRITE: begin
              if (wr_ptr < TOK_MAX) begin
                work_nxt[{wr_ptr, 2'b00} +: 4] = in_token;
                wr_ptr_nxt = wr_ptr + 7'd1;
              end else begin
                overflow_nxt = 1'b1;
              end
            end
            CMD_BACKSPACE: begin
              if (wr_ptr != 7'd0) begin
                wr_ptr_nxt = wr_ptr - 7'd1;
                work_nxt[{wr_ptr_nxt, 2'b00} +: 4] = BLANK;
              end
            end
            CMD_NEWLINE: begin
              wr_ptr_nxt = (nl_ptr > {1'b0, TOK_MAX}) ? TOK_MAX : nl_ptr[6:0];
            end
            CMD_CLEAR: begin
              state_nxt    = CLEAR;
              wr_ptr_nxt   = 7'd0;
              overflow_nxt = 1'b0;
              clr_idx_nxt  = 7'd0;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        work_nxt[{clr_idx, 2'b00} +: 4] = BLANK;
        clr_idx_nxt = clr_idx + 7'd1;
        if (clr_idx == TOK_MAX - 7'd1) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, working buffer and published buffer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      work        <= {TOKENS{BLANK}};
      numbers     <= {TOKENS{BLANK}};
      wr_ptr      <= 7'd0;
      overflow    <= 1'b0;
      clr_idx     <= 7'd0;
      commit_pend <= 1'b0;
    end else begin
      state       <= state_nxt;
      work        <= work_nxt;
      wr_ptr      <= wr_ptr_nxt;
      overflow    <= overflow_nxt;
      clr_idx     <= clr_idx_nxt;
      // A fresh edge in the commit cycle stays pending; edges while pending collapse.
      commit_pend <= (commit_pend & ~frame_commit) | vs_fall;
      if (frame_commit) begin
        numbers <= work_nxt;
      end
    end
  end

endmodule

// File: tb/tb_token_buffer_writer.sv
// Scoreboard bench for token_buffer_writer: the driver pushes the expected
// published buffer whenever it issues a vsync edge; a monitor pops on every
// frame_commit and compares against the buffer seen on the following cycle.
module tb_token_buffer_writer;

  localparam logic [383:0] ALL_F = {96{4'hF}};
  localparam logic [1:0] C_WR = 2'b00, C_BS = 2'b01, C_CLR = 2'b10, C_NL = 2'b11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_cmd = 2'b00;
  logic [3:0]   in_token = 4'h0;
  logic         vga_v_sync = 1'b1;
  logic [383:0] numbers;
  logic [6:0]   wr_ptr;
  logic         overflow;
  logic         frame_commit;

  int checks = 0;
  int failures = 0;
  int commit_count = 0;

  logic [383:0] exp_q[$];
  logic [383:0] m_buf;
  int           m_ptr;
  logic         m_ovf;

  token_buffer_writer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_token(in_token), .vga_v_sync(vga_v_sync),
    .numbers(numbers), .wr_ptr(wr_ptr), .overflow(overflow),
    .frame_commit(frame_commit)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [383:0] act, input logic [383:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every commit must be expected and must publish the expected buffer
  always @(negedge clk) begin
    if (rst_n && frame_commit) begin
      commit_count++;
      chk("commit_in_idle", 384'(in_ready), 384'(1));
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit actual=1 required=0");
      end else begin
        logic [383:0] e;
        e = exp_q.pop_front();
        @(posedge clk);
        #1;
        chk("committed_numbers", numbers, e);
      end
    end
  end

  task automatic model_reset();
    m_buf = ALL_F; m_ptr = 0; m_ovf = 1'b0;
  endtask

  task automatic send(input logic [1:0] cmd, input logic [3:0] tok);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL ready_timeout actual=0 required=1");
    end
    in_valid = 1'b1; in_cmd = cmd; in_token = tok;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    case (cmd)
      C_WR: if (m_ptr < 96) begin m_buf[4*m_ptr +: 4] = tok; m_ptr++; end else m_ovf = 1'b1;
      C_BS: if (m_ptr > 0) begin m_ptr--; m_buf[4*m_ptr +: 4] = 4'hF; end
      C_NL: begin m_ptr = (m_ptr / 20 + 1) * 20; if (m_ptr > 96) m_ptr = 96; end
      default: model_reset();
    endcase
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 300) begin n++; @(negedge clk); end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL idle_timeout actual=0 required=1");
    end
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vga_v_sync = 1'b0;
    repeat (4) @(negedge clk);
    vga_v_sync = 1'b1;
  endtask

  task automatic commit_frame();
    int n = 0;
    exp_q.push_back(m_buf);
    vsync_pulse();
    while (exp_q.size() != 0 && n < 50) begin n++; @(negedge clk); end
    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL commit_timeout actual=pending required=committed");
      exp_q.delete();
    end
  endtask

  initial begin
    int n;
    int c0;
    model_reset();
    #3 rst_n = 1'b0;
    #1;
    chk("reset_numbers", numbers, ALL_F);
    chk("reset_wr_ptr", 384'(wr_ptr), 384'(0));
    chk("reset_overflow", 384'(overflow), 384'(0));
    chk("reset_commit", 384'(frame_commit), 384'(0));
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_ready", 384'(in_ready), 384'(1));

    // 1: four tokens then a frame edge
    send(C_WR, 4'h1); send(C_WR, 4'h2); send(C_WR, 4'hA); send(C_WR, 4'h3);
    chk("t1_numbers_before_vsync", numbers, ALL_F);
    c0 = commit_count;
    commit_frame();
    chk("t1_low_slots", 384'(numbers[15:0]), 384'(16'h3A21));
    chk("t1_high_slots", 384'(numbers[383:16]), 384'({92{4'hF}}));
    chk("t1_wr_ptr", 384'(wr_ptr), 384'(4));
    chk("t1_one_commit", 384'(commit_count - c0), 384'(1));

    // 2: fill past the end
    send(C_CLR, 4'h0); wait_idle();
    for (int i = 0; i < 97; i++) send(C_WR, 4'h5);
    chk("t2_wr_ptr_full", 384'(wr_ptr), 384'(96));
    chk("t2_overflow", 384'(overflow), 384'(1));
    commit_frame();
    chk("t2_all_five", numbers, {96{4'h5}});
    send(C_BS, 4'h0);
    chk("t2_bs_ptr", 384'(wr_ptr), 384'(95));
    commit_frame();
    chk("t2_slot95_blank", 384'(numbers[383:380]), 384'(4'hF));
    chk("t2_slot94_kept", 384'(numbers[379:376]), 384'(4'h5));

    // 3: newline and backspace boundaries
    send(C_CLR, 4'h0); wait_idle();
    chk("t3_clear_overflow", 384'(overflow), 384'(0));
    send(C_WR, 4'h1); send(C_WR, 4'h2); send(C_WR, 4'h3);
    send(C_NL, 4'h0);
    chk("t3_nl_from_3", 384'(wr_ptr), 384'(20));
    send(C_NL, 4'h0);
    chk("t3_nl_col0", 384'(wr_ptr), 384'(40));
    for (int i = 0; i < 45; i++) send(C_WR, 4'(i % 10));
    chk("t3_at_85", 384'(wr_ptr), 384'(85));
    send(C_NL, 4'h0);
    chk("t3_nl_clamp", 384'(wr_ptr), 384'(96));
    commit_frame();
    send(C_WR, 4'h9);
    chk("t3_overflow_again", 384'(overflow), 384'(1));
    send(C_CLR, 4'h0); wait_idle();
    send(C_BS, 4'h0);
    chk("t3_bs_at_zero", 384'(wr_ptr), 384'(0));

    // 4: clear with a frame edge in the middle
    send(C_WR, 4'h4); send(C_WR, 4'h8);
    send(C_WR, 4'h6);
    m_ovf = 1'b0;
    c0 = commit_count;
    send(C_CLR, 4'h0);
    exp_q.push_back(ALL_F);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      if (n == 10) vga_v_sync = 1'b0;
      if (n == 14) vga_v_sync = 1'b1;
      @(negedge clk);
    end
    chk("t4_ready_low_cycles", 384'(n), 384'(96));
    repeat (4) @(negedge clk);
    chk("t4_single_commit", 384'(commit_count - c0), 384'(1));
    chk("t4_numbers_blank", numbers, ALL_F);
    chk("t4_overflow", 384'(overflow), 384'(0));

    // 5: edit without a frame edge stays hidden; two edges collapse
    send(C_WR, 4'h7);
    repeat (10) @(negedge clk);
    chk("t5_hidden_edit", numbers, ALL_F);
    c0 = commit_count;
    send(C_CLR, 4'h0);
    exp_q.push_back(ALL_F);
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      n++;
      if (n == 10 || n == 30) vga_v_sync = 1'b0;
      if (n == 14 || n == 34) vga_v_sync = 1'b1;
      @(negedge clk);
    end
    repeat (6) @(negedge clk);
    chk("t5_collapsed_commit", 384'(commit_count - c0), 384'(1));
    send(C_WR, 4'h7);
    commit_frame();
    chk("t5_slot0_seven", 384'(numbers[3:0]), 384'(4'h7));

    // 6: asynchronous reset in the middle of a clear
    send(C_CLR, 4'h0);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_numbers", numbers, ALL_F);
    chk("t6_wr_ptr", 384'(wr_ptr), 384'(0));
    chk("t6_commit", 384'(frame_commit), 384'(0));
    exp_q.delete();
    model_reset();
    #10 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_ready_after", 384'(in_ready), 384'(1));
    send(C_WR, 4'hB);
    chk("t6_write_after", 384'(wr_ptr), 384'(1));
    commit_frame();

    chk("final_queue_empty", 384'(exp_q.size()), 384'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
